// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: operation encoding and the
// bitwise operation function used by every datapath that evaluates an op.
package logic_unit_pkg;

    // Widest operand the shared function handles. Bitwise ops never carry
    // between bit positions, so narrower users zero-extend their operands in
    // and truncate the result back out. Instances must keep WIDTH at or below
    // this value.
    localparam int LOGIC_MAX_W = 256;

    typedef logic [LOGIC_MAX_W-1:0] word_t;

    // 3-bit operation code as presented on the op port.
    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_NOT_A = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASS  = 3'd7
    } op_t;

    // Pure bitwise evaluation of one operation. Ops NOT_A and PASS ignore b.
    function automatic word_t logic_f(op_t op, word_t a, word_t b);
        word_t r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XOR:   r = a ^ b;
            OP_NOT_A: r = ~a;
            OP_XNOR:  r = ~(a ^ b);
            OP_PASS:  r = a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Combinational WIDTH-bit wrapper around the shared logic function.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Widen the operands, evaluate, and keep only the low WIDTH bits; the
    // upper bits of the wide result carry no information for this width.
    assign y = WIDTH'(logic_f(op_t'(op), word_t'(a), word_t'(b)));

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit with an optional accumulator
// feeding operand b. Stage 1 holds the raw result; stage 2 is the output
// register carrying y together with its zero and parity flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             par
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] r;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;

    // Each stage may load when it is empty or when its content moves on in
    // the same cycle. in_ready depends on out_ready only, never on in_valid.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    // Select operand b: the accumulator when chaining, with a coincident
    // clear substituting the clear value so the op sees a freshly cleared acc.
    always_comb begin
        // NOTE: assign a default first so every path drives b_eff and no latch is inferred.
        b_eff = b;
        if (use_acc) begin
            b_eff = acc_clr ? ACC_INIT : acc;
        end
    end

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (op),
        .a  (a),
        .b  (b_eff),
        .y  (r)
    );

    // Stage 1: capture the fresh result whenever a transaction is accepted.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            // NOTE: data registers are reset too, so no X leaks out of a held-but-invalid stage.
            s1_r     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_r <= r;
            end
        end
    end

    // Stage 2: move the stage-1 result to the outputs and derive its flags;
    // everything holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            par       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y    <= s1_r;
                zero <= (s1_r == '0);
                par  <= ^s1_r;
            end
        end
    end

    // Accumulator: a chained accept writes its own result, which the very
    // next accept sees without a bubble; otherwise a clear restores ACC_INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= ACC_INIT;
        end else if (accept && use_acc) begin
            acc <= r;
        end else if (acc_clr) begin
            acc <= ACC_INIT;
        end
    end

endmodule
